// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipeline_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } ctrl_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int unsigned DEFAULT_CNT_W       = 16;
  localparam int unsigned DEFAULT_MEM_TIMEOUT = 64;

endpackage : pipeline_ctrl_pkg

// File: rtl/sat_counter.sv
// Up-counter that holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : sat_counter

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencing for the 5-stage pipe: load-use, memory wait, branch flush,
// plus saturating performance counters and a sticky memory-timeout flag.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = DEFAULT_CNT_W,
  parameter int unsigned MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_write_reg,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             mem_branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             ex_mem_flush,
  output logic             mem_wr_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  ctrl_state_t       state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;

  logic mem_wait;
  logic branch_flush;
  logic load_use;
  logic src_match;

  assign mem_wait     = mem_req && !mem_ready;
  assign branch_flush = (state_q == RUN) && mem_branch_taken && !mem_wait;
  assign src_match    = (ex_write_reg == id_rs) || (id_uses_rt && (ex_write_reg == id_rt));
  assign load_use     = (state_q == RUN) && !mem_wait && !mem_branch_taken &&
                        ex_mem_read && (ex_write_reg != REG_ZERO) && src_match;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next state and enables; memory wait outranks branch flush outranks load-use.
  always_comb begin
    state_d       = RUN;
    wait_cnt_d    = '0;
    timeout_d     = timeout_q;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_write  = 1'b1;
    ex_mem_flush  = 1'b0;
    mem_wr_bubble = 1'b0;

    if (reset) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_write   = 1'b0;
      id_ex_flush   = 1'b1;
      ex_mem_write  = 1'b0;
      ex_mem_flush  = 1'b1;
      mem_wr_bubble = 1'b1;
    end else if (mem_wait) begin
      state_d       = MEM_WAIT;
      wait_cnt_d    = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
      timeout_d     = timeout_q || (wait_cnt_d == WAIT_MAX);
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wr_bubble = 1'b1;
    end else if (branch_flush) begin
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      ex_mem_flush  = 1'b1;
    end else if (load_use) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_flush   = 1'b1;
    end
  end

  assign mem_timeout = timeout_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!reset && !pc_write),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (branch_flush && !reset),
    .count (flush_events)
  );

endmodule : pipeline_hazard_ctrl

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage MIPS pipeline. It sequences the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers:
- detects load-use hazards;
- freezes the pipe while data memory is not ready;
- flushes wrong-path instructions after a taken branch resolved in MEM.

It also keeps saturating stall/flush performance counters and a sticky memory-timeout flag.

Parameters:
CNT_W, 16, width of the stall and flush performance counters
MEM_TIMEOUT, 64, MEM_WAIT cycles after which mem_timeout is set (≥2)

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rt  in  1  instruction in ID reads rt (R-type, beq, sw)
ex_mem_read  in  1  instruction in EX is a load
ex_write_reg  in  5  destination register of the instruction in EX
mem_req  in  1  instruction in MEM accesses data memory (lw/sw)
mem_ready  in  1  data memory completes the access this cycle
mem_branch_taken  in  1  taken branch resolved in MEM this cycle
pc_write  out  1  PC load enable
if_id_write  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID loads a bubble
id_ex_write  out  1  ID/EX load enable
id_ex_flush  out  1  ID/EX loads a bubble (control bits zero)
ex_mem_write  out  1  EX/MEM load enable
ex_mem_flush  out  1  EX/MEM loads a bubble
mem_wr_bubble  out  1  MEM/WB captures reg_write=0, mem_to_reg=0
mem_timeout  out  1  sticky: MEM_WAIT lasted ≥ MEM_TIMEOUT cycles
stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0
flush_events  out  CNT_W  saturating count of branch flushes

Behaviour:
State register:
- Two states, RUN and MEM_WAIT, plus wait_cnt (ceil(log2(MEM_TIMEOUT+1)) bits).
- Enable/flush outputs are combinational from state and current inputs.

Reset (synchronous):
- While reset=1: state←RUN; wait_cnt, stall_cycles, flush_events, mem_timeout←0.
- While reset=1, outputs are forced to: all *_write=0, all *_flush=1, mem_wr_bubble=1.
- Reset asserted mid-MEM_WAIT aborts the wait; the following cycle is RUN.

Default (no hazard): every *_write=1, every *_flush=0, mem_wr_bubble=0.

Priority (highest first): memory wait > branch flush > load-use.

Memory wait:
- Condition: mem_req=1 and mem_ready=0 (in either state).
- Outputs: pc_write, if_id_write, id_ex_write, ex_mem_write all 0; mem_wr_bubble=1.
- State: RUN→MEM_WAIT; wait_cnt increments, saturating at MEM_TIMEOUT.
- Timeout: when wait_cnt reaches MEM_TIMEOUT, mem_timeout←1; it clears only on reset.
- Completion: the cycle with mem_ready=1 produces default outputs, state→RUN, wait_cnt←0. Zero extra latency.
- A mem_branch_taken asserted during a memory wait is ignored.

Branch flush:
- Condition: state RUN and mem_branch_taken=1.
- Outputs: if_id_flush=id_ex_flush=ex_mem_flush=1; pc_write=1 (PC loads the target).
- flush_events += 1, saturating.
- Load-use is suppressed in the same cycle.
- Exactly one cycle; no extra state.

Load-use:
- Condition: state RUN, no branch flush, ex_mem_read=1, ex_write_reg≠0, and either ex_write_reg==id_rs or (id_uses_rt and ex_write_reg==id_rt).
- Outputs: pc_write=0, if_id_write=0, id_ex_flush=1. EX/MEM and MEM/WB advance normally.
- Exactly one stall cycle, because the load moves to MEM next cycle.

Counters:
- stall_cycles increments in every non-reset cycle with pc_write=0.
- Both counters stop at 2^CNT_W−1 (no wrap).

Decomposition:
- Package pipeline_ctrl_pkg holds:
  - ctrl_state_t enum {RUN, MEM_WAIT};
  - REG_ZERO=5'd0;
  - default CNT_W/MEM_TIMEOUT constants.
- One sub-module, sat_counter (parameter W; ports clk, reset, inc, count), instantiated twice for stall_cycles and flush_events.
- Hazard detection stays inline.

Test Plan:
1. Load-use: ex_mem_read=1, ex_write_reg=8, id_rs=8 for 1 cycle -> pc_write=0, if_id_write=0, id_ex_flush=1 for exactly that cycle; stall_cycles=1.
2. No hazard through $zero: ex_mem_read=1, ex_write_reg=0, id_rs=0 -> default outputs, stall_cycles stays 0. Also id_rt=8 with id_uses_rt=0 -> no stall.
3. Memory wait: mem_req=1, mem_ready=0 for 3 cycles then mem_ready=1 -> 3 cycles of all *_write=0 with mem_wr_bubble=1, then defaults; stall_cycles=3; mem_timeout=0.
4. Branch vs load-use: mem_branch_taken=1 together with a load-use match -> three flushes=1, pc_write=1, id_ex_flush=1, if_id_write=1; flush_events=1, stall_cycles=0. Then mem_branch_taken=1 during MEM_WAIT -> ignored, flush_events unchanged.
5. Timeout and reset: MEM_TIMEOUT=4, mem_ready=0 held 6 cycles -> mem_timeout=1 from the 4th wait cycle. Reset pulse -> forced reset outputs while reset=1; state RUN, mem_timeout=0 and counters 0 on the next cycle.
6. Saturation: CNT_W=3, 10 load-use stalls -> stall_cycles=7 and stays at 7.
